riscv_divider: RTL and testbench

RISCV_DIVIDER -- requirements
Module: riscv_divider

---
 rtl/riscv_div_pkg.sv | 38 +++
 rtl/div_step.sv | 31 +++
 rtl/riscv_divider.sv | 133 +++++++++++++
 tb/tb_riscv_divider.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_div_pkg.sv
// Shared definitions for the iterative RISC-V M-extension divider.
// Holds the op encodings, the controller state enumeration, the iteration
// count and small helpers that decode the op field.
package riscv_div_pkg;

    localparam int ITER = 32;
    // Value of the 6-bit iteration counter on the final CALC cycle.
    localparam logic [5:0] LAST_ITER = 6'(ITER - 1);

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Magnitude of a two's-complement value; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_in   partial remainder entering the step (always < divisor)
//   dvd_in   dividend bits still to be consumed, MSB first; quotient bits
//            accumulate in the low end as the dividend shifts out
//   divisor  divisor magnitude
//   rem_out  partial remainder after the step
//   dvd_out  shifted dividend with the new quotient bit in bit 0
module div_step (
    input  logic [31:0] rem_in,
    input  logic [31:0] dvd_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic [31:0] dvd_out
);

    logic [32:0] shifted;
    logic [32:0] trial;
    logic        borrow;
    logic [32:0] rem_sel;
    logic        unused_rem_msb;

    assign shifted         = {rem_in, dvd_in[31]};
    assign {borrow, trial} = {1'b0, shifted} - {2'b00, divisor};
    assign rem_sel         = borrow ? shifted : trial;
    // The selected remainder is always below the divisor, so bit 32 is zero.
    assign unused_rem_msb  = rem_sel[32];
    assign rem_out         = rem_sel[31:0];
    assign dvd_out         = {dvd_in[30:0], ~borrow};

endmodule

// File: rtl/riscv_divider.sv
// Fixed-latency 32-bit divider for RISC-V DIV/DIVU/REM/REMU.
// A request is latched when start is high in IDLE or DONE, then 32 restoring
// steps run in CALC, FIX applies sign correction and the divide-by-zero rule,
// and DONE pulses done for one cycle. Latency is the same for every operand.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        request, honoured only while busy is low
//   op           00 DIV, 01 DIVU, 10 REM, 11 REMU
//   A, B         dividend and divisor
//   busy         high in CALC and FIX
//   done         one-cycle pulse, result valid
//   result       quotient or remainder, held until the next FIX cycle
module riscv_divider
    import riscv_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    div_state_e  state_reg, state_next;
    logic        accept;

    logic        rem_sel_reg;
    logic        q_neg_reg;
    logic        r_neg_reg;
    logic [5:0]  cnt_reg;
    logic [31:0] rem_reg;
    logic [31:0] dvd_reg;
    logic [31:0] divisor_reg;
    logic [31:0] result_reg;

    logic [31:0] rem_step;
    logic [31:0] dvd_step;
    logic [31:0] result_next;

    div_step u_step (
        .rem_in  (rem_reg),
        .dvd_in  (dvd_reg),
        .divisor (divisor_reg),
        .rem_out (rem_step),
        .dvd_out (dvd_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (cnt_reg == LAST_ITER) state_next = S_FIX;
            end
            S_FIX: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_CALC;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Sign correction. After 32 steps dvd_reg holds the quotient magnitude
    // and rem_reg the remainder magnitude. A zero divisor leaves an all-ones
    // magnitude quotient, but for signed DIV the sign flip must be suppressed,
    // so quotients by zero are forced to all ones. The signed-overflow case
    // needs no special handling: |0x80000000|/1 negated is 0x80000000.
    always_comb begin
        result_next = '0;
        if (rem_sel_reg)
            result_next = r_neg_reg ? (~rem_reg + 32'd1) : rem_reg;
        else if (divisor_reg == '0)
            result_next = '1;
        else
            result_next = q_neg_reg ? (~dvd_reg + 32'd1) : dvd_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_sel_reg <= 1'b0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            dvd_reg     <= '0;
            divisor_reg <= '0;
            result_reg  <= '0;
        end else if (accept) begin
            rem_sel_reg <= op_is_rem(op);
            q_neg_reg   <= op_is_signed(op) & (A[31] ^ B[31]);
            r_neg_reg   <= op_is_signed(op) & A[31];
            cnt_reg     <= '0;
            rem_reg     <= '0;
            dvd_reg     <= op_is_signed(op) ? abs32(A) : A;
            divisor_reg <= op_is_signed(op) ? abs32(B) : B;
        end else if (state_reg == S_CALC) begin
            rem_reg <= rem_step;
            dvd_reg <= dvd_step;
            cnt_reg <= cnt_reg + 6'd1;
        end else if (state_reg == S_FIX) begin
            result_reg <= result_next;
        end
    end

    assign result = result_reg;

endmodule

// File: tb/tb_riscv_divider.sv
// Self-checking bench for riscv_divider: directed corner cases, randomized
// operations against an arithmetic reference, back-to-back start flooding
// and reset abort.
module tb_riscv_divider;
    import riscv_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests  = 0;
    int failed = 0;
    logic [31:0] last_result;

    riscv_divider dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int signed sa;
        int signed sb;
        logic      ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b11:   return (b == 0) ? a : a % b;
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            default: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Caller is 1 time unit after a rising edge with the DUT idle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int          early;
        exp   = ref_div(o, a, b);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;                       // edge T
        start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
        check({tag, " busy_calc"}, {31'b0, busy}, 32'd1);
        early = 0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            if (done) early++;
        end
        check({tag, " busy_fix"}, {31'b0, busy}, 32'd1);
        check({tag, " early_done"}, 32'(early), 32'd0);
        check({tag, " result_hold"}, result, last_result);
        @(posedge clk); #1;                       // done cycle, ends at edge T+34
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " busy_done"}, {31'b0, busy}, 32'd0);
        check({tag, " result"}, result, exp);
        $display("[TB] %s op=%0d A=%h B=%h result=%h expected=%h", tag, o, a, b, result, exp);
        last_result = exp;
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, " result_after"}, result, exp);
    endtask

    logic [1:0]  s_op [40];
    logic [31:0] s_a  [40];
    logic [31:0] s_b  [40];

    initial begin
        int          dcount;
        int          didx;
        int          wait_cnt;
        logic [31:0] dres;
        logic [31:0] busy34;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        last_result = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases
        run_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
        run_op(OP_REMU, 32'd100, 32'd7, "remu_100_7");
        run_op(OP_DIV,  32'hFFFF_FF9C, 32'd7, "div_m100_7");
        run_op(OP_REM,  32'hFFFF_FF9C, 32'd7, "rem_m100_7");
        run_op(OP_DIV,  32'h1234_5678, 32'd0, "div_by0");
        run_op(OP_DIVU, 32'h1234_5678, 32'd0, "divu_by0");
        run_op(OP_REM,  32'h1234_5678, 32'd0, "rem_by0");
        run_op(OP_REMU, 32'h1234_5678, 32'd0, "remu_by0");
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd0, "div_neg_by0");

        // Randomized operations with biased corner selection
        for (int n = 0; n < 20; n++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: ;
            endcase
            run_op(ro, ra, rb, $sformatf("rand%0d", n));
        end

        // start held high for 40 cycles with changing operands
        dcount = 0; didx = -1; dres = '0; busy34 = '0;
        for (int i = 0; i < 40; i++) begin
            s_op[i] = 2'($urandom);
            s_a[i]  = $urandom;
            s_b[i]  = (i == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            start = 1'b1; op = s_op[i]; A = s_a[i]; B = s_b[i];
            @(posedge clk); #1;                   // edge T+i
            if (done) begin
                dcount++;
                if (didx < 0) begin didx = i; dres = result; end
            end
            if (i == 34) busy34 = {31'b0, busy};
        end
        start = 1'b0;
        check("flood done_count", 32'(dcount), 32'd1);
        check("flood done_edge", 32'(didx), 32'd33);
        check("flood result1", dres, ref_div(s_op[0], s_a[0], s_b[0]));
        check("flood accept_in_done", busy34, 32'd1);
        $display("[TB] flood op=%0d A=%h B=%h result=%h", s_op[0], s_a[0], s_b[0], dres);
        wait_cnt = 0;
        while (!done && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("flood second_latency", 32'(wait_cnt), 32'd28);
        check("flood result2", result, ref_div(s_op[34], s_a[34], s_b[34]));
        $display("[TB] flood2 op=%0d A=%h B=%h result=%h", s_op[34], s_a[34], s_b[34], result);
        last_result = ref_div(s_op[34], s_a[34], s_b[34]);
        @(posedge clk); #1;

        // Reset in the middle of CALC
        start = 1'b1; op = OP_DIVU; A = $urandom; B = 32'd5;
        @(posedge clk); #1;                       // edge T
        start = 1'b0;
        repeat (10) @(posedge clk);               // edge T+10
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("abort no_done", 32'(dcount), 32'd0);
        rst_n = 1'b1;
        last_result = '0;
        run_op(OP_DIVU, 32'd9, 32'd3, "post_reset_divu_9_3");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
